telemetry_framer: RTL and testbench
===================================

Name: telemetry_framer

Overview:
- Upstream stage of the 115200-baud UART transmitter.
- On a start pulse, snapshots a block of sensor/status bytes (moisture, temperature, light, health flags) and emits one framed packet, one byte at a time.
- Framing is SYNC, SEQ, payload, CHECKSUM, sent over a valid/ready byte handshake that matches the transmitter's one-cycle-accept, ready-drops-next-cycle behaviour.
- Keeps an 8-bit frame sequence counter and a sticky overrun flag for start requests that arrive while a frame is in progress.

Parameters:
- NUM_BYTES, 4, payload length in bytes, legal range 1..16.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle frame request.
- data_in  input  8*NUM_BYTES  payload; byte k = data_in[8k+7:8k]; byte 0 is sent first.
- tx_data  output  8  byte to the UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter is idle and can accept a byte.
- busy  output  1  a frame is in progress (state != IDLE).
- done  output  1  one-cycle pulse after the CHECKSUM byte is accepted.
- seq  output  8  sequence number the next frame will carry.
- overrun  output  1  sticky; set when start is high while busy.

Behaviour:
- Reset is asynchronous, active-low, on clk. All outputs clear immediately: tx_valid=0, tx_data=0, busy=0, done=0, seq=0, overrun=0. State returns to IDLE and the byte index to 0. A reset mid-frame abandons the frame with no further bytes.
- Frame layout, NUM_BYTES+3 bytes in order:
  - SYNC_BYTE
  - seq
  - payload bytes 0..NUM_BYTES-1
  - CHECKSUM = XOR of seq and all payload bytes (SYNC excluded)
- Transfer rule: a byte is transferred on a rising edge where tx_valid and tx_ready are both high.
- States:
  - IDLE: tx_valid=0. On start, latch data_in and seq into a shadow register, set byte index to 0, go to SEND.
  - SEND: tx_valid=1, tx_data=current frame byte.
    - On transfer, if this was the CHECKSUM byte, go to DONE.
    - Otherwise increment the byte index and go to GAP.
    - While tx_ready is low, hold tx_valid and tx_data stable.
  - GAP: tx_valid=0 for exactly one cycle, then go to WAITRDY. This guarantees the transmitter's ready has dropped, so no double-accept occurs.
  - WAITRDY: tx_valid=0. Go to SEND on the first cycle tx_ready is sampled high.
  - DONE: done=1 for one cycle; seq increments by 1 (wraps 8'hFF to 8'h00); go to IDLE.
- Latency:
  - start in IDLE at edge N gives tx_valid=1 with tx_data=SYNC_BYTE from edge N+1.
  - The minimum gap between consecutive accepted bytes is 3 cycles, but the transmitter's byte time dominates.
- Checksum is computed incrementally as bytes are sent:
  - Cleared on frame load.
  - XORed with each SEQ and payload byte at its transfer.
  - The CHECKSUM byte is driven from the accumulator.
- The payload is taken from the snapshot only. Changes to data_in after the start edge have no effect on the current frame.
- start while busy, including the DONE cycle: the request is ignored, overrun is set to 1 and stays set until reset. seq is unaffected.
- start and DONE never overlap as an accepted start. A new frame can begin at the earliest on the cycle after DONE (back in IDLE).
- If tx_ready is stuck low, the block waits indefinitely with no timeout.
- Byte index width: $clog2(NUM_BYTES+3).

Decomposition:
- Shared package (telemetry_pkg):
  - framer state encoding (IDLE, SEND, GAP, WAITRDY, DONE)
  - default SYNC_BYTE
  - payload byte-position constants for moisture=0, temperature=1, light=2, status=3; the status bit layout is {health[1:0], pump, fan, alarm, 3'b0}.
- No sub-module: a single FSM with a shadow register, byte mux and checksum accumulator.
- The top level instantiates telemetry_framer feeding uart_tx directly.

Test Plan:
- Basic frame: NUM_BYTES=4, data_in=32'h44332211, start after reset, framer connected to uart_tx with CLKS_PER_BIT=8 -> bytes A5,00,11,22,33,44,44 decoded from the serial line; done pulses once; seq=01.
- Second frame with the same data -> A5,01,11,22,33,44,45; seq=02. Preload to seq=FF (255 frames) -> that frame carries FF and seq wraps to 00.
- Stalled ready from a bench model holding tx_ready low for 20 cycles in SEND -> tx_valid and tx_data held stable. Each byte is accepted exactly once; no duplicate byte on the line.
- start pulsed mid-frame, and data_in changed mid-frame -> overrun=1, the frame content is unchanged from the snapshot, and no second frame is sent.
- rst_n asserted during payload byte 2 -> tx_valid=0, busy=0, seq=0 and overrun=0 immediately. A new start after release sends a clean frame beginning with A5,00.
- NUM_BYTES=1, data_in=8'h5A -> A5,00,5A,5A; done pulses once.

Source files
------------

// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry framer: FSM encoding, default sync byte,
// payload byte positions and the status-byte layout.
package telemetry_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_GAP     = 3'd2;
  localparam logic [2:0] ST_WAITRDY = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam int POS_MOISTURE    = 0;
  localparam int POS_TEMPERATURE = 1;
  localparam int POS_LIGHT       = 2;
  localparam int POS_STATUS      = 3;

  typedef struct packed {
    logic [1:0] health;
    logic       pump;
    logic       fan;
    logic       alarm;
    logic [2:0] rsvd;
  } status_t;

  function automatic logic [7:0] pack_status(input logic [1:0] health, input logic pump,
                                             input logic fan, input logic alarm);
    status_t s;
    s.health = health;
    s.pump   = pump;
    s.fan    = fan;
    s.alarm  = alarm;
    s.rsvd   = 3'b000;
    return s;
  endfunction

endpackage

// File: rtl/telemetry_framer.sv
// Snapshots a payload on start and emits SYNC, SEQ, payload, CHECKSUM one byte
// at a time to a UART transmitter whose ready drops the cycle after an accept.
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int         NUM_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] data_in,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             seq,
  output logic                   overrun,
  output logic [2:0]             dbg_state
);

  localparam int            IW       = $clog2(NUM_BYTES + 3);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES + 2);

  // Handshake: a byte moves on a rising edge with tx_valid && tx_ready both high;
  // tx_valid/tx_data stay stable in SEND until that edge.
  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
  logic [7:0]             frame_seq_q, frame_seq_d;
  logic [7:0]             csum_q, csum_d;
  logic [7:0]             seq_q, seq_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             cur_byte;

  always_comb begin
    cur_byte = csum_q;
    if (idx_q == '0) begin
      cur_byte = SYNC_BYTE;
    end else if (idx_q == IW'(1)) begin
      cur_byte = frame_seq_q;
    end else if (idx_q != LAST_IDX) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (idx_q == IW'(k + 2)) cur_byte = shadow_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    frame_seq_d = frame_seq_q;
    csum_d      = csum_q;
    seq_d       = seq_q;
    overrun_d   = overrun_q | (start && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d    = data_in;
          frame_seq_d = seq_q;
          idx_d       = '0;
          csum_d      = 8'h00;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            // SYNC is excluded from the checksum.
            if (idx_q != '0) csum_d = csum_q ^ cur_byte;
            idx_d   = idx_q + IW'(1);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP:     state_d = ST_WAITRDY;
      ST_WAITRDY: if (tx_ready) state_d = ST_SEND;
      ST_DONE: begin
        seq_d   = seq_q + 8'd1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      frame_seq_q <= 8'h00;
      csum_q      <= 8'h00;
      seq_q       <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      frame_seq_q <= frame_seq_d;
      csum_q      <= csum_d;
      seq_q       <= seq_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tx_valid  = (state_q == ST_SEND);
  assign tx_data   = tx_valid ? cur_byte : 8'h00;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign seq       = seq_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer: a 4-byte and a 1-byte instance driven by a
// transmitter model whose ready drops for a byte time after every accept.
module tb_telemetry_framer;
  import telemetry_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a[2];
  logic [31:0] data0;
  logic [7:0] data1;
  logic [7:0] tx_data_a[2];
  logic       tx_valid_a[2];
  logic       tx_ready_a[2];
  logic       busy_a[2];
  logic       done_a[2];
  logic [7:0] seq_a[2];
  logic       overrun_a[2];
  logic [2:0] dbg_a[2];

  int n_tests = 0;
  int n_fail  = 0;
  int bt      = 10;
  logic stall = 1'b0;
  int cnt[2];
  int done_cnt[2];
  logic acc[2];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  fseq;
    logic [7:0]  csum;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  telemetry_framer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .data_in(data0),
    .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]), .tx_ready(tx_ready_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .seq(seq_a[0]), .overrun(overrun_a[0]),
    .dbg_state(dbg_a[0])
  );

  telemetry_framer #(.NUM_BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .data_in(data1),
    .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]), .tx_ready(tx_ready_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .seq(seq_a[1]), .overrun(overrun_a[1]),
    .dbg_state(dbg_a[1])
  );

  // Transmitter model: log accepted bytes, then hold ready low for bt cycles.
  always begin
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      acc[g] = tx_valid_a[g] && tx_ready_a[g];
      if (acc[g]) got_q.push_back(tx_data_a[g]);
      if (done_a[g]) done_cnt[g]++;
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) cnt[g] = 0;
      else if (acc[g]) cnt[g] = bt;
      else if (cnt[g] > 0) cnt[g]--;
      tx_ready_a[g] = (cnt[g] == 0) && !stall;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] s, input logic [31:0] d, input int nb);
    logic [7:0] c;
    c = s;
    for (int k = 0; k < nb; k++) c = c ^ d[8*k +: 8];
    return c;
  endfunction

  task automatic push_exp(input logic [7:0] fseq, input logic [31:0] d, input int nb,
                          input logic [7:0] csum);
    exp_q.push_back(8'hA5);
    exp_q.push_back(fseq);
    for (int k = 0; k < nb; k++) exp_q.push_back(d[8*k +: 8]);
    exp_q.push_back(csum);
  endtask

  task automatic pulse_start(input int g, input logic [31:0] d);
    @(posedge clk); #2;
    if (g == 0) data0 = d;
    else data1 = d[7:0];
    start_a[g] = 1'b1;
    @(posedge clk); #2;
    start_a[g] = 1'b0;
    check("lat_valid", 32'(tx_valid_a[g]), 32'd1);
    check("lat_sync", 32'(tx_data_a[g]), 32'hA5);
    check("lat_busy", 32'(busy_a[g]), 32'd1);
  endtask

  task automatic wait_done(input int g);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (done_a[g]) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic finish_frame(input int g, input int dc, input logic [7:0] nseq);
    logic [7:0] a;
    logic [7:0] e;
    repeat (3) @(posedge clk);
    #2;
    check("done_pulses", 32'(done_cnt[g] - dc), 32'd1);
    check("idle_busy", 32'(busy_a[g]), 32'd0);
    check("seq_next", 32'(seq_a[g]), 32'(nseq));
    check("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      check("frame_byte", 32'(a), 32'(e));
    end
    got_q.delete();
  endtask

  task automatic run_frame(input int g, input logic [31:0] d, input int nb,
                           input logic [7:0] fseq, input logic [7:0] csum);
    int dc;
    dc = done_cnt[g];
    push_exp(fseq, d, nb, csum);
    pulse_start(g, d);
    wait_done(g);
    finish_frame(g, dc, fseq + 8'd1);
  endtask

  initial begin
    int dc;
    logic reached;
    start_a[0] = 1'b0;
    start_a[1] = 1'b0;
    data0 = '0;
    data1 = '0;

    vecs[0] = '{32'h44332211, 8'h00, 8'h44};
    vecs[1] = '{32'h44332211, 8'h01, 8'h45};
    vecs[2] = '{{pack_status(2'b10, 1'b1, 1'b0, 1'b1), 8'h80, 8'h19, 8'h3C}, 8'h02, 8'h0F};
    vecs[3] = '{32'hFFFFFFFF, 8'h03, 8'h03};
    vecs[4] = '{32'h00000000, 8'h04, 8'h04};

    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 2; g++) begin
      check("rst_valid", 32'(tx_valid_a[g]), 32'd0);
      check("rst_data", 32'(tx_data_a[g]), 32'd0);
      check("rst_busy", 32'(busy_a[g]), 32'd0);
      check("rst_done", 32'(done_a[g]), 32'd0);
      check("rst_seq", 32'(seq_a[g]), 32'd0);
      check("rst_overrun", 32'(overrun_a[g]), 32'd0);
    end
    check("status_pack", 32'(vecs[2].data[8*POS_STATUS +: 8]), 32'hA8);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    for (int i = 0; i < 5; i++) run_frame(0, vecs[i].data, 4, vecs[i].fseq, vecs[i].csum);

    // Ready held low in SEND: SYNC must stay presented and unaccepted.
    stall = 1'b1;
    repeat (2) @(posedge clk);
    dc = done_cnt[0];
    push_exp(8'h05, 32'hA1B2C3D4, 4, csum_of(8'h05, 32'hA1B2C3D4, 4));
    pulse_start(0, 32'hA1B2C3D4);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      check("stall_valid", 32'(tx_valid_a[0]), 32'd1);
      check("stall_data", 32'(tx_data_a[0]), 32'hA5);
    end
    check("stall_no_accept", 32'(got_q.size()), 32'd0);
    stall = 1'b0;
    wait_done(0);
    finish_frame(0, dc, 8'h06);

    bt = 1;
    exp_seq = 8'h06;
    while (exp_seq != 8'hFF) begin
      run_frame(0, {exp_seq, ~exp_seq, 8'h5A, exp_seq ^ 8'h33}, 4, exp_seq,
                csum_of(exp_seq, {exp_seq, ~exp_seq, 8'h5A, exp_seq ^ 8'h33}, 4));
      exp_seq++;
    end
    run_frame(0, 32'h44332211, 4, 8'hFF, 8'hBB);
    bt = 10;

    // start and data change mid-frame.
    check("overrun_pre", 32'(overrun_a[0]), 32'd0);
    dc = done_cnt[0];
    push_exp(8'h00, 32'hDEADBEEF, 4, csum_of(8'h00, 32'hDEADBEEF, 4));
    pulse_start(0, 32'hDEADBEEF);
    repeat (15) @(posedge clk);
    #2;
    data0 = 32'h12345678;
    start_a[0] = 1'b1;
    @(posedge clk); #2;
    start_a[0] = 1'b0;
    check("overrun_set", 32'(overrun_a[0]), 32'd1);
    check("overrun_busy", 32'(busy_a[0]), 32'd1);
    wait_done(0);
    finish_frame(0, dc, 8'h01);
    repeat (40) @(posedge clk);
    #2;
    check("no_extra_frame", 32'(got_q.size()), 32'd0);
    check("overrun_sticky", 32'(overrun_a[0]), 32'd1);
    check("seq_after_overrun", 32'(seq_a[0]), 32'h01);

    // Reset while payload byte 2 is pending.
    pulse_start(0, 32'h44332211);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (got_q.size() >= 4) begin
        reached = 1'b1;
        break;
      end
    end
    check("reach_byte2", 32'(reached), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(tx_valid_a[0]), 32'd0);
    check("mid_rst_data", 32'(tx_data_a[0]), 32'd0);
    check("mid_rst_busy", 32'(busy_a[0]), 32'd0);
    check("mid_rst_seq", 32'(seq_a[0]), 32'd0);
    check("mid_rst_overrun", 32'(overrun_a[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    run_frame(0, 32'h44332211, 4, 8'h00, 8'h44);

    // start during the DONE cycle is ignored and flags overrun.
    dc = done_cnt[0];
    push_exp(8'h01, 32'h44332211, 4, 8'h45);
    pulse_start(0, 32'h44332211);
    wait_done(0);
    start_a[0] = 1'b1;
    @(posedge clk); #2;
    start_a[0] = 1'b0;
    check("done_cycle_overrun", 32'(overrun_a[0]), 32'd1);
    finish_frame(0, dc, 8'h02);
    repeat (40) @(posedge clk);
    #2;
    check("done_cycle_no_frame", 32'(got_q.size()), 32'd0);
    check("done_cycle_seq", 32'(seq_a[0]), 32'h02);

    run_frame(1, 32'h0000005A, 1, 8'h00, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
